// File: rtl/ifmap_row_feeder.sv
// ifmap_row_feeder: tags each raw IFMap sample with start/end-of-row flags and writes it to the IFMap buffer.
// Latency: combinational pass-through; an accepted sample is written to the buffer in the same cycle.
// Backpressure: in_ready mirrors ready_buf_IFMap while streaming; counters, state and lengths hold when stalled.
module ifmap_row_feeder #(
  parameter int DATA_WIDTH    = 16,
  parameter int ROW_LEN_WIDTH = 4,
  parameter int ROW_CNT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Start,
  input  logic [ROW_LEN_WIDTH-1:0] row_len_in,
  input  logic [ROW_CNT_WIDTH-1:0] num_rows_in,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     ready_buf_IFMap,
  output logic                     wen_buf_IFMap,
  output logic [DATA_WIDTH+1:0]    IFMap_wdata,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [ROW_LEN_WIDTH-1:0] LEN_ONE = 1;
  localparam logic [ROW_CNT_WIDTH-1:0] ROW_ONE = 1;

  state_t                   state_q,    state_d;
  logic [ROW_LEN_WIDTH-1:0] row_len_q,  row_len_d;
  logic [ROW_LEN_WIDTH-1:0] col_cnt_q,  col_cnt_d;
  logic [ROW_CNT_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [ROW_CNT_WIDTH-1:0] row_cnt_q,  row_cnt_d;

  logic sor;
  logic eor;
  logic last_row;

  // Row-position flags; the "-1" wraps in counter width, but zero lengths never reach STREAM.
  assign sor      = (col_cnt_q == '0);
  assign eor      = (col_cnt_q == (row_len_q - LEN_ONE));
  assign last_row = (row_cnt_q == (num_rows_q - ROW_ONE));

  // Next-state, counter update and the combinational write path to the buffer.
  always_comb begin
    state_d       = state_q;
    row_len_d     = row_len_q;
    num_rows_d    = num_rows_q;
    col_cnt_d     = col_cnt_q;
    row_cnt_d     = row_cnt_q;
    in_ready      = 1'b0;
    wen_buf_IFMap = 1'b0;
    IFMap_wdata   = '0;
    done          = 1'b0;
    busy          = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          row_len_d  = row_len_in;
          num_rows_d = num_rows_in;
          col_cnt_d  = '0;
          row_cnt_d  = '0;
          // An empty job skips straight to the completion pulse.
          if ((row_len_in == '0) || (num_rows_in == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_STREAM;
          end
        end
      end

      S_STREAM: begin
        in_ready = ready_buf_IFMap;
        if (in_valid && ready_buf_IFMap) begin
          wen_buf_IFMap = 1'b1;
          IFMap_wdata   = {sor, eor, in_data};
          if (eor) begin
            col_cnt_d = '0;
            row_cnt_d = row_cnt_q + ROW_ONE;
            if (last_row) begin
              state_d = S_DONE;
            end
          end else begin
            col_cnt_d = col_cnt_q + LEN_ONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched job lengths and position counters; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_len_q  <= '0;
      num_rows_q <= '0;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_len_q  <= row_len_d;
      num_rows_q <= num_rows_d;
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

endmodule

// File: tb/tb_ifmap_row_feeder.sv
// tb_ifmap_row_feeder: directed and randomized stimulus for ifmap_row_feeder against a job-level reference model.
// Latency: not applicable (bench).
// Backpressure: the bench drives ready_buf_IFMap directly, including stalls.
module tb_ifmap_row_feeder;
  localparam int DW = 16;
  localparam int LW = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [LW-1:0] row_len_in;
  logic [RW-1:0] num_rows_in;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ready_buf_IFMap;
  logic          wen_buf_IFMap;
  logic [DW+1:0] IFMap_wdata;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  ifmap_row_feeder #(.DATA_WIDTH(DW), .ROW_LEN_WIDTH(LW), .ROW_CNT_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .Start(Start), .row_len_in(row_len_in), .num_rows_in(num_rows_in),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ready_buf_IFMap(ready_buf_IFMap), .wen_buf_IFMap(wen_buf_IFMap), .IFMap_wdata(IFMap_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Job-level reference model: mode 0 = idle, 1 = streaming, 2 = completion cycle.
  // m_k counts words written so far in the job; flags come from m_k modulo row length.
  int m_mode  = 0;
  int m_k     = 0;
  int m_total = 0;
  int m_L     = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      m_k    = 0;
    end else begin
      case (m_mode)
        0: if (Start) begin
          m_L     = int'(row_len_in);
          m_total = int'(row_len_in) * int'(num_rows_in);
          m_k     = 0;
          m_mode  = (m_total == 0) ? 2 : 1;
        end
        1: if (in_valid && ready_buf_IFMap) begin
          m_k++;
          if (m_k == m_total) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
  end

  // Per-cycle comparison plus logs of writes, job start and done cycles for the directed checks.
  logic [DW+1:0] wlog_d[$];
  int            wlog_c[$];
  int            start_cyc = 0;
  int            done_cyc  = -1;

  always @(negedge clk) begin
    logic          e_rdy, e_wen;
    logic [DW+1:0] e_wd;
    int            col;
    if (cmp_en) begin
      e_rdy = (m_mode == 1) && ready_buf_IFMap;
      e_wen = e_rdy && in_valid;
      e_wd  = '0;
      if (e_wen) begin
        col  = m_k % m_L;
        e_wd = {(col == 0), (col == m_L - 1), in_data};
      end
      chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
      chk("wen", {31'd0, wen_buf_IFMap}, {31'd0, e_wen});
      chk("wdata", {14'd0, IFMap_wdata}, {14'd0, e_wd});
      chk("busy", {31'd0, busy}, {31'd0, (m_mode != 0)});
      chk("done", {31'd0, done}, {31'd0, (m_mode == 2)});
      if (wen_buf_IFMap) begin
        wlog_d.push_back(IFMap_wdata);
        wlog_c.push_back(cyc);
      end
      if (done) done_cyc = cyc;
      if (Start && !rst && (m_mode == 0)) start_cyc = cyc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs;
    wlog_d.delete();
    wlog_c.delete();
    done_cyc = -1;
  endtask

  task automatic start_job(input int L, input int R);
    Start       = 1'b1;
    row_len_in  = LW'(L);
    num_rows_in = RW'(R);
    tick;
    Start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (1) begin
      #1;
      if (in_ready) begin
        tick;
        break;
      end
      tick;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $display("FAIL send_timeout cyc=%0d got=no_accept expected=accept", cyc);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy) begin
      tick;
      n++;
      if (n > 2000) begin
        checks++;
        failures++;
        $display("FAIL idle_timeout cyc=%0d got=busy expected=idle", cyc);
        break;
      end
    end
  endtask

  task automatic chk_words(input string nm, input logic [DW+1:0] exp[$]);
    chk({nm, "_count"}, wlog_d.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wlog_d.size(); i++) begin
      chk($sformatf("%s_w%0d", nm, i), {14'd0, wlog_d[i]}, {14'd0, exp[i]});
    end
  endtask

  task automatic chk_flags(input string nm, input logic [1:0] exp[$]);
    chk({nm, "_count"}, wlog_d.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wlog_d.size(); i++) begin
      chk($sformatf("%s_f%0d", nm, i), {30'd0, wlog_d[i][DW+1:DW]}, {30'd0, exp[i]});
    end
  endtask

  initial begin
    logic [DW+1:0] ew[$];
    logic [1:0]    ef[$];
    rst = 1'b1; Start = 1'b0; row_len_in = '0; num_rows_in = '0;
    in_data = '0; in_valid = 1'b0; ready_buf_IFMap = 1'b1;
    tick;
    cmp_en = 1'b1;
    tick;
    rst = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_wdata", {14'd0, IFMap_wdata}, 32'd0);

    // Basic single row.
    clear_logs;
    start_job(3, 1);
    send(16'hFFD7); send(16'h0029); send(16'hFFD3);
    wait_idle;
    ew = '{18'h2FFD7, 18'h00029, 18'h1FFD3};
    chk_words("row3", ew);
    if (wlog_c.size() == 3) begin
      chk("row3_first_cyc", wlog_c[0], start_cyc + 1);
      chk("row3_last_cyc", wlog_c[2], start_cyc + 3);
    end
    chk("row3_done_cyc", done_cyc, start_cyc + 4);

    // Single-sample rows.
    clear_logs;
    start_job(1, 2);
    send(16'h0009); send(16'h001C);
    wait_idle;
    ew = '{18'h30009, 18'h3001C};
    chk_words("len1", ew);
    chk("len1_done_cyc", done_cyc, start_cyc + 3);

    // Multi-row job.
    clear_logs;
    start_job(2, 3);
    for (int i = 1; i <= 6; i++) send(DW'(i));
    wait_idle;
    ef = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    chk_flags("multi", ef);
    chk("multi_done_cyc", done_cyc, start_cyc + 7);

    // Backpressure mid-row.
    clear_logs;
    start_job(4, 1);
    send(16'h00A1); send(16'h00A2);
    ready_buf_IFMap = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h00A3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_wen", {31'd0, wen_buf_IFMap}, 32'd0);
      tick;
    end
    ready_buf_IFMap = 1'b1;
    send(16'h00A3); send(16'h00A4);
    wait_idle;
    ew = '{18'h200A1, 18'h000A2, 18'h000A3, 18'h100A4};
    chk_words("stall", ew);

    // Zero-length job, then a restart attempt in the middle of a stream.
    clear_logs;
    start_job(0, 3);
    wait_idle;
    chk("zero_count", wlog_d.size(), 0);
    chk("zero_done_cyc", done_cyc, start_cyc + 1);
    clear_logs;
    start_job(2, 2);
    send(16'h0101);
    Start = 1'b1; row_len_in = 4'd5; num_rows_in = 4'd7;
    tick;
    Start = 1'b0;
    send(16'h0102); send(16'h0103); send(16'h0104);
    wait_idle;
    ew = '{18'h20101, 18'h10102, 18'h20103, 18'h10104};
    chk_words("restart", ew);

    // Reset mid-job.
    clear_logs;
    start_job(4, 1);
    send(16'h0001); send(16'h0002);
    in_valid = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wen", {31'd0, wen_buf_IFMap}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wdata", {14'd0, IFMap_wdata}, 32'd0);
    in_valid = 1'b0;
    clear_logs;
    start_job(2, 1);
    send(16'h0007); send(16'h0008);
    wait_idle;
    ew = '{18'h20007, 18'h10008};
    chk_words("after_rst", ew);

    // Randomized jobs with random stalls, gaps, stray Start pulses and occasional reset.
    for (int j = 0; j < 40; j++) begin
      wait_idle;
      start_job($urandom_range(0, 6), $urandom_range(0, 4));
      for (int c = 0; c < 2000; c++) begin
        in_valid        = ($urandom % 4) != 0;
        ready_buf_IFMap = ($urandom % 4) != 0;
        in_data         = DW'($urandom);
        Start           = ($urandom % 8) == 0;
        row_len_in      = LW'($urandom);
        num_rows_in     = RW'($urandom);
        rst             = ($urandom % 97) == 0;
        tick;
        if (!busy) break;
      end
      rst = 1'b0; Start = 1'b0; in_valid = 1'b0; ready_buf_IFMap = 1'b1;
      tick;
    end
    wait_idle;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
